updown_monitor: RTL and testbench

UPDOWN_MONITOR -- requirements
Module: updown_monitor

---
 rtl/updown_monitor.sv | 103 ++++++++++
 tb/tb_updown_monitor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_monitor.sv
// Sequence monitor for a 3-bit up/down counter.
// Checks every step against the applied direction, counts net wraps, and latches the first violation.
module updown_monitor #(
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic              u,
    input  logic [DATA_W-1:0] cnt,
    output logic [1:0]        state,
    output logic              wrap_up,
    output logic              wrap_dn,
    output logic signed [7:0] laps,
    output logic              err,
    output logic [DATA_W-1:0] bad_val,
    output logic [DATA_W-1:0] exp_val
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARM   = 2'b01,
        TRACK = 2'b10,
        ERROR = 2'b11
    } state_t;

    localparam logic signed [7:0] LAPS_MAX = 8'sh7F;
    localparam logic signed [7:0] LAPS_MIN = 8'sh80;

    state_t            fsm;
    logic [DATA_W-1:0] cnt_q;
    logic              u_q;
    logic [DATA_W-1:0] exp_next;
    logic              step_ok;
    logic              is_wrap_up;
    logic              is_wrap_dn;

    // Saturating +/-1 on the signed lap counter; never wraps around.
    function automatic logic signed [7:0] laps_step(input logic signed [7:0] cur,
                                                    input logic up);
        if (up)
            return (cur == LAPS_MAX) ? cur : cur + 8'sd1;
        else
            return (cur == LAPS_MIN) ? cur : cur - 8'sd1;
    endfunction

    assign state      = fsm;
    assign exp_next   = u_q ? cnt_q + DATA_W'(1) : cnt_q - DATA_W'(1);
    assign step_ok    = (cnt == exp_next);
    assign is_wrap_up = u_q  && (cnt_q == '1) && (cnt == '0);
    assign is_wrap_dn = !u_q && (cnt_q == '0) && (cnt == '1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm     <= IDLE;
            cnt_q   <= '0;
            u_q     <= 1'b0;
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
            laps    <= '0;
            err     <= 1'b0;
            bad_val <= '0;
            exp_val <= '0;
        end else begin
            cnt_q   <= cnt;
            u_q     <= u;
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
            // clr outranks enable, violations and wraps seen on the same sample
            if (clr) begin
                fsm     <= IDLE;
                laps    <= '0;
                err     <= 1'b0;
                bad_val <= '0;
                exp_val <= '0;
            end else begin
                case (fsm)
                    IDLE:  if (en) fsm <= ARM;
                    ARM:   fsm <= en ? TRACK : IDLE;
                    TRACK: begin
                        if (!en) begin
                            fsm <= IDLE;
                        end else if (!step_ok) begin
                            fsm     <= ERROR;
                            err     <= 1'b1;
                            bad_val <= cnt;
                            exp_val <= exp_next;
                        end else if (is_wrap_up) begin
                            wrap_up <= 1'b1;
                            laps    <= laps_step(laps, 1'b1);
                        end else if (is_wrap_dn) begin
                            wrap_dn <= 1'b1;
                            laps    <= laps_step(laps, 1'b0);
                        end
                    end
                    ERROR: fsm <= ERROR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_updown_monitor.sv
// Randomized and directed bench for updown_monitor against a step-level reference model.
module tb_updown_monitor;

    logic              clk;
    logic              reset;
    logic              en;
    logic              clr;
    logic              u;
    logic [2:0]        cnt;
    logic [1:0]        state;
    logic              wrap_up;
    logic              wrap_dn;
    logic signed [7:0] laps;
    logic              err;
    logic [2:0]        bad_val;
    logic [2:0]        exp_val;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: 0 idle, 1 arm, 2 track, 3 error
    int m_state, m_prev, m_prevu, m_laps, m_err, m_bad, m_exp, m_wu, m_wd;

    logic [2:0] v, ctr;
    int         nwrap;
    string      phase;

    updown_monitor dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clr     (clr),
        .u       (u),
        .cnt     (cnt),
        .state   (state),
        .wrap_up (wrap_up),
        .wrap_dn (wrap_dn),
        .laps    (laps),
        .err     (err),
        .bad_val (bad_val),
        .exp_val (exp_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_prevu = 0; m_laps = 0;
        m_err = 0; m_bad = 0; m_exp = 0; m_wu = 0; m_wd = 0;
    endtask

    task automatic model_edge();
        int expv;
        m_wu = 0;
        m_wd = 0;
        if (clr) begin
            m_state = 0; m_laps = 0; m_err = 0; m_bad = 0; m_exp = 0;
        end else begin
            case (m_state)
                0: if (en) m_state = 1;
                1: m_state = en ? 2 : 0;
                2: begin
                    if (!en) begin
                        m_state = 0;
                    end else begin
                        expv = m_prevu ? (m_prev + 1) % 8 : (m_prev + 7) % 8;
                        if (int'(cnt) != expv) begin
                            m_state = 3; m_err = 1; m_bad = int'(cnt); m_exp = expv;
                        end else if (m_prevu == 1 && int'(cnt) < m_prev) begin
                            m_wu = 1;
                            m_laps = (m_laps < 127) ? m_laps + 1 : 127;
                        end else if (m_prevu == 0 && int'(cnt) > m_prev) begin
                            m_wd = 1;
                            m_laps = (m_laps > -128) ? m_laps - 1 : -128;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_prev  = int'(cnt);
        m_prevu = int'(u);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/state"},   int'(state),   m_state);
        check({tag, "/wrap_up"}, int'(wrap_up), m_wu);
        check({tag, "/wrap_dn"}, int'(wrap_dn), m_wd);
        check({tag, "/laps"},    int'(laps),    m_laps);
        check({tag, "/err"},     int'(err),     m_err);
        check({tag, "/bad_val"}, int'(bad_val), m_bad);
        check({tag, "/exp_val"}, int'(exp_val), m_exp);
        check({tag, "/wrap_excl"}, int'(wrap_up & wrap_dn), 0);
    endtask

    task automatic cycle(input logic e, input logic c, input logic d, input logic [2:0] val);
        en  = e;
        clr = c;
        u   = d;
        cnt = val;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(phase);
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b0;
        model_reset();
        #1 compare_all({phase, "/async_rst"});
        #1 reset = 1'b1;
        #1 compare_all({phase, "/rel_pre_edge"});
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; clr = 1'b0; u = 1'b0; cnt = 3'd0;
        model_reset();
        phase = "por";
        repeat (2) @(posedge clk);
        #1 compare_all("por");
        #2 reset = 1'b1;
        #1 compare_all("release_pre_edge");
        cycle(1'b0, 1'b0, 1'b0, 3'd4);
        check("idle_hold", int'(state), 0);

        phase = "up_wrap";
        cycle(1'b1, 1'b0, 1'b1, 3'd5);  check("r035_arm", int'(state), 1);
        cycle(1'b1, 1'b0, 1'b1, 3'd6);  check("r035_track", int'(state), 2);
        cycle(1'b1, 1'b0, 1'b1, 3'd7);  check("r035_no_wrap_yet", int'(wrap_up), 0);
        cycle(1'b1, 1'b0, 1'b1, 3'd0);  check("r035_wrap_up", int'(wrap_up), 1);
        check("r035_laps", int'(laps), 1);
        cycle(1'b1, 1'b0, 1'b1, 3'd1);  check("r035_pulse_end", int'(wrap_up), 0);
        check("r035_err", int'(err), 0);

        phase = "dn_wrap";
        cycle(1'b1, 1'b0, 1'b0, 3'd2);
        cycle(1'b1, 1'b0, 1'b0, 3'd1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd7);  check("r036_wrap_dn", int'(wrap_dn), 1);
        check("r036_laps", int'(laps), 0);
        cycle(1'b1, 1'b0, 1'b0, 3'd6);  check("r036_pulse_end", int'(wrap_dn), 0);

        phase = "violation";
        cycle(1'b1, 1'b0, 1'b0, 3'd5);
        cycle(1'b1, 1'b0, 1'b0, 3'd4);
        cycle(1'b1, 1'b0, 1'b1, 3'd3);
        cycle(1'b1, 1'b0, 1'b1, 3'd5);
        check("r037_state", int'(state), 3);
        check("r037_err", int'(err), 1);
        check("r037_bad", int'(bad_val), 5);
        check("r037_exp", int'(exp_val), 4);
        cycle(1'b1, 1'b0, 1'b1, 3'd6);
        cycle(1'b1, 1'b0, 1'b1, 3'd7);
        cycle(1'b1, 1'b0, 1'b1, 3'd0);  check("r037_no_wrap_in_err", int'(wrap_up), 0);
        cycle(1'b0, 1'b0, 1'b1, 3'd1);  check("r037_err_hold_en0", int'(state), 3);
        cycle(1'b1, 1'b1, 1'b1, 3'd2);
        check("r037_clr_state", int'(state), 0);
        check("r037_clr_err", int'(err), 0);
        check("r037_clr_bad", int'(bad_val), 0);

        phase = "saturate";
        v = 3'd2;
        cycle(1'b1, 1'b0, 1'b1, v);
        nwrap = 0;
        for (int i = 0; i < 1200 && nwrap < 128; i++) begin
            v = v + 3'd1;
            cycle(1'b1, 1'b0, 1'b1, v);
            if (wrap_up) nwrap++;
        end
        check("r038_up_wraps", nwrap, 128);
        check("r038_laps_max", int'(laps), 127);
        check("r038_last_pulse", int'(wrap_up), 1);
        v = 3'd1;
        cycle(1'b1, 1'b0, 1'b0, v);
        nwrap = 0;
        for (int i = 0; i < 2500 && nwrap < 256; i++) begin
            v = v - 3'd1;
            cycle(1'b1, 1'b0, 1'b0, v);
            if (wrap_dn) nwrap++;
        end
        check("r038_dn_wraps", nwrap, 256);
        check("r038_laps_min", int'(laps), -128);

        phase = "clr_vs_wrap";
        cycle(1'b1, 1'b0, 1'b1, 3'd6);
        cycle(1'b1, 1'b0, 1'b1, 3'd7);
        cycle(1'b1, 1'b1, 1'b1, 3'd0);
        check("r039_no_wrap", int'(wrap_up), 0);
        check("r039_laps", int'(laps), 0);
        check("r039_state", int'(state), 0);

        phase = "rst_in_err";
        cycle(1'b1, 1'b0, 1'b1, 3'd1);
        cycle(1'b1, 1'b0, 1'b1, 3'd2);
        cycle(1'b1, 1'b0, 1'b1, 3'd5);
        check("r040_err_set", int'(err), 1);
        async_reset_pulse();
        check("r040_err_cleared", int'(err), 0);
        cycle(1'b1, 1'b0, 1'b1, 3'd3);  check("r040_arm", int'(state), 1);
        cycle(1'b1, 1'b0, 1'b1, 3'd4);  check("r040_track", int'(state), 2);

        phase = "random";
        ctr = 3'd5;
        for (int i = 0; i < 2000; i++) begin
            logic e, c, d;
            e = ($urandom_range(0, 99) < 93);
            c = ($urandom_range(0, 99) < 2);
            d = 1'(($urandom_range(0, 99) < 60) ? 1 : 0);
            v = ($urandom_range(0, 99) < 4) ? 3'($urandom_range(0, 7)) : ctr;
            cycle(e, c, d, v);
            ctr = d ? v + 3'd1 : v - 3'd1;
            if ($urandom_range(0, 199) == 0) async_reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
